nec_prefetch_queue: RTL and testbench

Producer side of the instruction prefetch queue (IPQ) interface consumed by the instruction decoder. It fetches code bytes from the bus at PS:fetch_ptr into an 8-entry byte ring buffer and presents that buffer as ipq[8]/ipq_len. The decoder reads the buffer directly, indexed by its own pc[2:0]. A set_pc flush retargets fetching and discards any stale in-flight data.

---
 rtl/nec_prefetch_queue_pkg.sv | 11 +
 rtl/nec_prefetch_queue_if.sv | 24 ++
 rtl/nec_prefetch_queue.sv | 124 ++++++++++++
 tb/tb_nec_prefetch_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue and the decoder.
package nec_prefetch_queue_pkg;

  localparam int unsigned IPQ_DEPTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } prefetch_state_e;

endpackage

// File: rtl/nec_prefetch_queue_if.sv
// Code-fetch bus between the prefetch queue (master) and the bus unit (slave).
interface nec_prefetch_queue_if;
  logic        bus_req;
  logic [19:0] bus_addr;
  logic        bus_odd;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_addr,
    output bus_odd,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    input  bus_odd,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/nec_prefetch_queue.sv
// Instruction prefetch queue producer: fetches code bytes at PS:fetch_ptr into
// an 8-byte ring the decoder indexes with its own pc[2:0].
module nec_prefetch_queue
  import nec_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH         = IPQ_DEPTH,
  parameter int unsigned EVEN_FREE_MIN = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce_1,
  input  logic                 ce_2,
  input  logic [15:0]          ps,
  input  logic                 set_pc,
  input  logic [15:0]          new_pc,
  input  logic [15:0]          dec_pc,
  input  logic                 prefetch_en,
  output logic [7:0]           ipq [DEPTH],
  output logic [3:0]           ipq_len,
  nec_prefetch_queue_if.master bus
);

  prefetch_state_e state_q, state_d;
  logic [15:0] fetch_ptr_q, fetch_ptr_d;
  logic        primed_q, primed_d;
  logic        discard_q, discard_d;
  logic        bus_req_q, bus_req_d;
  logic [19:0] bus_addr_q, bus_addr_d;
  logic        bus_odd_q, bus_odd_d;
  logic [7:0]  ipq_q [DEPTH];
  logic [7:0]  ipq_d [DEPTH];

  logic        ce;
  logic [3:0]  free;
  logic [19:0] phys_addr;
  logic [2:0]  wp, wp1;
  logic        can_issue;

  assign ce        = ce_1 | ce_2;
  assign ipq_len   = primed_q ? 4'(fetch_ptr_q - dec_pc) : 4'd0;
  assign free      = 4'(DEPTH) - ipq_len;
  assign phys_addr = ({ps, 4'h0} + {4'h0, fetch_ptr_q}) & 20'hFFFFE;
  assign wp        = fetch_ptr_q[2:0];
  assign wp1       = wp + 3'd1;
  assign can_issue = primed_q && prefetch_en && !set_pc &&
                     (fetch_ptr_q[0] ? (free >= 4'd1) : (free >= 4'(EVEN_FREE_MIN)));

  assign ipq          = ipq_q;
  assign bus.bus_req  = bus_req_q;
  assign bus.bus_addr = bus_addr_q;
  assign bus.bus_odd  = bus_odd_q;

  // Next-state: request issue, response capture and set_pc retargeting.
  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    primed_d    = primed_q;
    discard_d   = discard_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_odd_d   = bus_odd_q;
    ipq_d       = ipq_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (can_issue) begin
            state_d    = REQ;
            bus_req_d  = 1'b1;
            bus_addr_d = phys_addr;
            bus_odd_d  = fetch_ptr_q[0];
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
            discard_d = 1'b0;
            // A set_pc coinciding with the ack drops the data outright.
            if (!discard_q && !set_pc) begin
              if (bus_odd_q) begin
                ipq_d[wp]   = bus.bus_rdata[15:8];
                fetch_ptr_d = fetch_ptr_q + 16'd1;
              end else begin
                ipq_d[wp]   = bus.bus_rdata[7:0];
                ipq_d[wp1]  = bus.bus_rdata[15:8];
                fetch_ptr_d = fetch_ptr_q + 16'd2;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (set_pc) begin
        fetch_ptr_d = new_pc;
        primed_d    = 1'b1;
        if (state_q == REQ && !bus.bus_ack) discard_d = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fetch_ptr_q <= '0;
      primed_q    <= 1'b0;
      discard_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_odd_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) ipq_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      primed_q    <= primed_d;
      discard_q   <= discard_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_odd_q   <= bus_odd_d;
      ipq_q       <= ipq_d;
    end
  end

endmodule

// File: tb/tb_nec_prefetch_queue.sv
// Self-checking bench for nec_prefetch_queue: expected bus requests are queued
// as stimulus is set up and popped when the DUT raises bus_req.
module tb_nec_prefetch_queue;
  import nec_prefetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_1, ce_2;
  logic [15:0] ps, new_pc, dec_pc;
  logic        set_pc, prefetch_en;
  logic [7:0]  ipq [IPQ_DEPTH];
  logic [3:0]  ipq_len;

  nec_prefetch_queue_if bus_if ();

  nec_prefetch_queue #(.DEPTH(IPQ_DEPTH), .EVEN_FREE_MIN(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_1        (ce_1),
    .ce_2        (ce_2),
    .ps          (ps),
    .set_pc      (set_pc),
    .new_pc      (new_pc),
    .dec_pc      (dec_pc),
    .prefetch_en (prefetch_en),
    .ipq         (ipq),
    .ipq_len     (ipq_len),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] addr;
    logic        odd;
  } req_t;

  req_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Queue can never report more than 8 bytes outside the set_pc cycle.
  always @(negedge clk)
    if (reset_n && !set_pc) check("len_le8", 32'(ipq_len <= 4'd8), 32'd1);

  task automatic expect_req(input logic [19:0] a, input logic o);
    req_t r;
    r.addr = a;
    r.odd  = o;
    exp_q.push_back(r);
  endtask

  task automatic wait_req(input string tag);
    req_t r;
    int unsigned n = 0;
    while (!bus_if.bus_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.bus_req) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(bus_if.bus_addr), 32'hFFFFFFFF);
      return;
    end
    r = exp_q.pop_front();
    check({tag, "_addr"}, 32'(bus_if.bus_addr), 32'(r.addr));
    check({tag, "_odd"}, 32'(bus_if.bus_odd), 32'(r.odd));
  endtask

  task automatic do_ack(input logic [15:0] d);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = d;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check("req_drop", 32'(bus_if.bus_req), 32'd0);
  endtask

  task automatic serve(input string tag, input logic [15:0] d);
    wait_req(tag);
    @(negedge clk);
    do_ack(d);
  endtask

  task automatic do_set_pc(input logic [15:0] v);
    set_pc = 1'b1;
    new_pc = v;
    dec_pc = v;
    @(negedge clk);
    set_pc = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce_1 = 1'b1; ce_2 = 1'b0; ps = 16'hF000;
    set_pc = 1'b0; new_pc = '0; dec_pc = '0; prefetch_en = 1'b1;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_addr", 32'(bus_if.bus_addr), 32'd0);
    check("rst_odd", 32'(bus_if.bus_odd), 32'd0);
    check("rst_len", 32'(ipq_len), 32'd0);
    for (int i = 0; i < IPQ_DEPTH; i++) check("rst_ipq", 32'(ipq[i]), 32'd0);
    reset_n = 1'b1;
    // Not primed until the first set_pc.
    repeat (5) @(negedge clk);
    check("unprimed_req", 32'(bus_if.bus_req), 32'd0);

    // Fill from 0x0100: four word fetches, then full.
    expect_req(20'hF0100, 1'b0); expect_req(20'hF0102, 1'b0);
    expect_req(20'hF0104, 1'b0); expect_req(20'hF0106, 1'b0);
    do_set_pc(16'h0100);
    for (int k = 0; k < 4; k++) begin
      serve("fill", {8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)});
      check("fill_len", 32'(ipq_len), 32'(2 * k + 2));
    end
    for (int i = 0; i < IPQ_DEPTH; i++) check("fill_ipq", 32'(ipq[i]), 32'(8'hA0 + i));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("full_noreq", 32'(bus_if.bus_req), 32'd0);
    end

    // 7 bytes held at even fetch_ptr: no word fetch until 2 free.
    dec_pc = 16'h0101;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("len7_noreq", 32'(bus_if.bus_req), 32'd0);
    end
    check("len7", 32'(ipq_len), 32'd7);
    expect_req(20'hF0108, 1'b0);
    dec_pc = 16'h0102;
    serve("free2", 16'hB9B8);
    prefetch_en = 1'b0;
    check("free2_len", 32'(ipq_len), 32'd8);
    check("free2_ipq0", 32'(ipq[0]), 32'hB8);
    check("free2_ipq1", 32'(ipq[1]), 32'hB9);

    // Odd retarget: single high-lane byte, then even words.
    prefetch_en = 1'b1;
    expect_req(20'hF0202, 1'b1); expect_req(20'hF0204, 1'b0);
    do_set_pc(16'h0203);
    serve("odd", 16'hAB00);
    check("odd_ipq3", 32'(ipq[3]), 32'hAB);
    check("odd_len", 32'(ipq_len), 32'd1);
    serve("odd_next", 16'hCDEF);
    prefetch_en = 1'b0;
    check("odd_ipq4", 32'(ipq[4]), 32'hEF);
    check("odd_ipq5", 32'(ipq[5]), 32'hCD);
    check("odd_len3", 32'(ipq_len), 32'd3);

    // set_pc while a request is pending: response discarded.
    prefetch_en = 1'b1;
    expect_req(20'hF0100, 1'b0);
    do_set_pc(16'h0100);
    wait_req("disc");
    prefetch_en = 1'b0;
    do_set_pc(16'h0500);
    check("disc_hold_req", 32'(bus_if.bus_req), 32'd1);
    check("disc_hold_addr", 32'(bus_if.bus_addr), 32'hF0100);
    do_ack(16'h1234);
    check("disc_len", 32'(ipq_len), 32'd0);
    check("disc_ipq0", 32'(ipq[0]), 32'hB8);
    check("disc_ipq1", 32'(ipq[1]), 32'hB9);
    prefetch_en = 1'b1;
    expect_req(20'hF0500, 1'b0);
    serve("disc_next", 16'h5566);
    prefetch_en = 1'b0;
    check("disc_next_ipq0", 32'(ipq[0]), 32'h66);
    check("disc_next_ipq1", 32'(ipq[1]), 32'h55);
    check("disc_next_len", 32'(ipq_len), 32'd2);

    // set_pc on the ack cycle: data dropped, discard not armed.
    prefetch_en = 1'b1;
    expect_req(20'hF0502, 1'b0);
    wait_req("same");
    @(negedge clk);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 16'h7777;
    set_pc = 1'b1; new_pc = 16'h0600; dec_pc = 16'h0600;
    @(negedge clk);
    bus_if.bus_ack = 1'b0; set_pc = 1'b0;
    check("same_req", 32'(bus_if.bus_req), 32'd0);
    check("same_len", 32'(ipq_len), 32'd0);
    check("same_ipq2", 32'(ipq[2]), 32'hA2);
    expect_req(20'hF0600, 1'b0);
    serve("same_next", 16'h9988);
    prefetch_en = 1'b0;
    check("same_next_ipq0", 32'(ipq[0]), 32'h88);
    check("same_next_ipq1", 32'(ipq[1]), 32'h99);
    check("same_next_len", 32'(ipq_len), 32'd2);

    // Offset wrap FFFE -> 0002, clocked by ce_2 only; ack ignored while ce low.
    ce_1 = 1'b0; ce_2 = 1'b1; prefetch_en = 1'b1;
    expect_req(20'hFFFFE, 1'b0); expect_req(20'hF0000, 1'b0);
    do_set_pc(16'hFFFE);
    wait_req("wrap");
    ce_2 = 1'b0;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 16'h2211;
    repeat (2) @(negedge clk);
    check("nce_req", 32'(bus_if.bus_req), 32'd1);
    check("nce_ipq6", 32'(ipq[6]), 32'hA6);
    check("nce_len", 32'(ipq_len), 32'd0);
    ce_2 = 1'b1;
    do_ack(16'h2211);
    serve("wrap2", 16'h4433);
    prefetch_en = 1'b0;
    check("wrap_ipq6", 32'(ipq[6]), 32'h11);
    check("wrap_ipq7", 32'(ipq[7]), 32'h22);
    check("wrap_ipq0", 32'(ipq[0]), 32'h33);
    check("wrap_ipq1", 32'(ipq[1]), 32'h44);
    check("wrap_len", 32'(ipq_len), 32'd4);
    ce_1 = 1'b1; ce_2 = 1'b0;

    // Physical address wraps mod 2^20.
    ps = 16'hFFFF; prefetch_en = 1'b1;
    expect_req(20'h00000, 1'b0);
    do_set_pc(16'h0010);
    serve("awrap", 16'hBEEF);
    prefetch_en = 1'b0;
    check("awrap_ipq0", 32'(ipq[0]), 32'hEF);
    check("awrap_ipq1", 32'(ipq[1]), 32'hBE);

    // Reset mid-request drops bus_req asynchronously.
    prefetch_en = 1'b1;
    expect_req(20'h00010, 1'b0);
    do_set_pc(16'h0020);
    wait_req("rstreq");
    #2 reset_n = 1'b0;
    #1;
    check("arst_req", 32'(bus_if.bus_req), 32'd0);
    check("arst_addr", 32'(bus_if.bus_addr), 32'd0);
    check("arst_len", 32'(ipq_len), 32'd0);
    check("arst_ipq0", 32'(ipq[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_unprimed", 32'(bus_if.bus_req), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
